// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player sequencer.
package maze_pkg;

  localparam int MAP_W   = 32;
  localparam int MAP_H   = 32;
  localparam int START_X = 1;
  localparam int START_Y = 7;

  typedef enum logic [1:0] {DIR_E, DIR_N, DIR_W, DIR_S} dir_t;
  typedef enum logic [1:0] {TURN_L, TURN_R, FWD, BACK} cmd_t;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_CHECK, S_REFRESH, S_DRAW} state_t;

  typedef struct packed {
    logic signed [5:0] dx;
    logic signed [5:0] dy;
  } step_t;

  // Screen y grows downward, so north is a negative y step.
  function automatic step_t step_vec(dir_t d);
    step_t s;
    s.dx = '0;
    s.dy = '0;
    case (d)
      DIR_E:   s.dx = 6'sd1;
      DIR_N:   s.dy = -6'sd1;
      DIR_W:   s.dx = -6'sd1;
      DIR_S:   s.dy = 6'sd1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command queue; push while full is legal when a pop happens in the same cycle.
module cmd_fifo
  import maze_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLOCK_50,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rstn && push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/move_sequencer.sv
// Queues key commands, checks moves against the wall ROM, commits position/heading
// and issues one draw_screen refresh per accepted command.
module move_sequencer #(
  parameter int MAP_W        = maze_pkg::MAP_W,
  parameter int MAP_H        = maze_pkg::MAP_H,
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAW_TIMEOUT = 2000000,
  parameter int START_X      = maze_pkg::START_X,
  parameter int START_Y      = maze_pkg::START_Y
) (
  input  logic       CLOCK_50,
  input  logic       rstn,
  input  logic [3:0] key_pressed,
  output logic [9:0] map_addr,
  output logic       map_rd,
  input  logic       map_data,
  output logic       refresh,
  input  logic       screen_busy,
  input  logic       screen_done,
  output logic [5:0] px,
  output logic [5:0] py,
  output logic [1:0] direction,
  output logic       bump,
  output logic       cmd_drop,
  output logic       draw_err,
  output logic       idle
);
  import maze_pkg::*;

  localparam int CW = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAW_TIMEOUT - 1);

  state_t            state, state_n;
  dir_t              dir_q;
  logic signed [5:0] px_q, py_q, tx, ty;
  logic [CW-1:0]     cnt;
  logic              draw_err_q;
  logic              key_any;
  cmd_t              key_cmd, head;
  logic              push, pop, full, empty;
  logic              in_bounds, wall, draw_over;
  logic              refresh_c, map_rd_c, bump_c;
  step_t             st;
  logic              unused_busy;

  assign unused_busy = screen_busy;

  always_comb begin
    key_any = |key_pressed;
    if (key_pressed[3])      key_cmd = TURN_L;
    else if (key_pressed[2]) key_cmd = TURN_R;
    else if (key_pressed[1]) key_cmd = FWD;
    else                     key_cmd = BACK;
  end

  assign pop  = (state == S_IDLE) && !empty;
  assign push = key_any && (!full || pop);

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .rstn     (rstn),
    .push     (push),
    .pop      (pop),
    .din      (key_cmd),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );

  assign st        = step_vec(dir_q);
  assign in_bounds = (int'(tx) >= 0) && (int'(tx) < MAP_W) && (int'(ty) >= 0) && (int'(ty) < MAP_H);
  assign wall      = !in_bounds || map_data;
  assign map_addr  = in_bounds ? 10'(int'(ty) * MAP_W + int'(tx)) : '0;
  assign draw_over = (cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) state <= S_INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    refresh_c = 1'b0;
    map_rd_c  = 1'b0;
    bump_c    = 1'b0;
    case (state)
      S_INIT: begin
        refresh_c = 1'b1;
        state_n   = S_DRAW;
      end
      S_IDLE: begin
        if (!empty) state_n = (head == TURN_L || head == TURN_R) ? S_REFRESH : S_FETCH;
      end
      S_FETCH: begin
        map_rd_c = in_bounds;
        state_n  = S_CHECK;
      end
      S_CHECK: begin
        bump_c  = wall;
        state_n = wall ? S_IDLE : S_REFRESH;
      end
      S_REFRESH: begin
        refresh_c = 1'b1;
        state_n   = S_DRAW;
      end
      S_DRAW: begin
        if (screen_done || draw_over) state_n = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      px_q       <= 6'(START_X);
      py_q       <= 6'(START_Y);
      dir_q      <= DIR_E;
      tx         <= '0;
      ty         <= '0;
      cnt        <= '0;
      draw_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            case (head)
              TURN_L:  dir_q <= dir_t'(dir_q + 2'd1);
              TURN_R:  dir_q <= dir_t'(dir_q - 2'd1);
              FWD: begin
                tx <= px_q + st.dx;
                ty <= py_q + st.dy;
              end
              default: begin
                tx <= px_q - st.dx;
                ty <= py_q - st.dy;
              end
            endcase
          end
        end
        S_CHECK: begin
          if (!wall) begin
            px_q <= tx;
            py_q <= ty;
          end
        end
        S_INIT, S_REFRESH: cnt <= '0;
        S_DRAW: begin
          if (!screen_done) begin
            if (draw_over) draw_err_q <= 1'b1;
            else           cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are qualified with rstn so they stay low while reset is held.
  assign refresh   = rstn & refresh_c;
  assign map_rd    = rstn & map_rd_c;
  assign bump      = rstn & bump_c;
  assign cmd_drop  = rstn & key_any & full & ~pop;
  assign px        = px_q;
  assign py        = py_q;
  assign direction = dir_q;
  assign draw_err  = draw_err_q;
  assign idle      = (state == S_IDLE) && empty;

endmodule

// File: tb/tb_move_sequencer.sv
// Randomized scoreboard bench for move_sequencer with a command-level player model.
module tb_move_sequencer;

  localparam int TO = 16;

  logic       CLOCK_50 = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] key_pressed = '0;
  logic [9:0] map_addr;
  logic       map_rd;
  logic       map_data = 1'b0;
  logic       refresh;
  logic       screen_busy = 1'b0;
  logic       screen_done = 1'b0;
  logic [5:0] px, py;
  logic [1:0] direction;
  logic       bump, cmd_drop, draw_err, idle;

  move_sequencer #(
    .MAP_W(32), .MAP_H(32), .FIFO_DEPTH(4), .DRAW_TIMEOUT(TO), .START_X(1), .START_Y(7)
  ) dut (
    .CLOCK_50(CLOCK_50), .rstn(rstn), .key_pressed(key_pressed),
    .map_addr(map_addr), .map_rd(map_rd), .map_data(map_data),
    .refresh(refresh), .screen_busy(screen_busy), .screen_done(screen_done),
    .px(px), .py(py), .direction(direction), .bump(bump), .cmd_drop(cmd_drop),
    .draw_err(draw_err), .idle(idle)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  bit wall_map [1024];
  always @(posedge CLOCK_50) map_data <= map_rd ? wall_map[map_addr] : 1'($urandom);

  typedef enum {EV_RD, EV_BUMP, EV_REF, EV_DROP} ev_kind_t;
  typedef struct {
    ev_kind_t k;
    int at;
    int addr;
    int x;
    int y;
    int d;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mx, my, md;
  bit  hold = 1'b0;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void expect_ev(ev_kind_t k, int at, int addr);
    ev_t e;
    e.k = k; e.at = at; e.addr = addr; e.x = mx; e.y = my; e.d = md;
    exp_q.push_back(e);
  endfunction

  // Player rules at command granularity: turns, step vectors, bounds and wall lookup.
  function automatic void model_cmd(logic [3:0] k, int n, bit timed);
    int s, dx, dy, tx, ty, a;
    if (k[3]) begin
      md = (md + 1) % 4;
      expect_ev(EV_REF, timed ? n + 2 : -1, 0);
    end else if (k[2]) begin
      md = (md + 3) % 4;
      expect_ev(EV_REF, timed ? n + 2 : -1, 0);
    end else begin
      s  = k[1] ? 1 : -1;
      dx = (md == 0) ? 1 : (md == 2) ? -1 : 0;
      dy = (md == 3) ? 1 : (md == 1) ? -1 : 0;
      tx = mx + s * dx;
      ty = my + s * dy;
      if (tx >= 0 && tx < 32 && ty >= 0 && ty < 32) begin
        a = ty * 32 + tx;
        expect_ev(EV_RD, n + 2, a);
        if (!wall_map[a]) begin
          mx = tx;
          my = ty;
          expect_ev(EV_REF, n + 4, 0);
          return;
        end
      end
      expect_ev(EV_BUMP, n + 3, 0);
    end
  endfunction

  function automatic void observe(ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({"unexpected ", k.name()}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("event kind", int'(k), int'(e.k));
    if (e.k != k) return;
    if (e.at >= 0) check({k.name(), " cycle"}, cyc, e.at);
    case (k)
      EV_RD: check("map_addr", int'(map_addr), e.addr);
      EV_BUMP, EV_REF: begin
        check({k.name(), " px"}, int'($signed(px)), e.x);
        check({k.name(), " py"}, int'($signed(py)), e.y);
        check({k.name(), " dir"}, int'(direction), e.d);
      end
      default: ;
    endcase
  endfunction

  always @(negedge CLOCK_50) begin
    if (rstn) begin
      if (cmd_drop) observe(EV_DROP);
      if (map_rd)   observe(EV_RD);
      if (bump)     observe(EV_BUMP);
      if (refresh)  observe(EV_REF);
    end
  end

  // draw_screen stand-in: busy after each refresh, done after a random delay unless held.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (refresh) begin
        screen_busy = 1'b1;
        repeat ($urandom_range(1, 10)) @(negedge CLOCK_50);
        while (hold) @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 screen_done = 1'b1;
        @(posedge CLOCK_50);
        #1 screen_done = 1'b0;
        screen_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_key(logic [3:0] k);
    key_pressed = k;
    tick();
    key_pressed = '0;
  endtask

  task automatic wait_idle(int budget);
    int i = 0;
    tick();
    while (!idle && i < budget) begin
      tick();
      i++;
    end
    check("idle reached", int'(idle), 1);
  endtask

  task automatic check_pos(string tag);
    check({tag, " px"}, int'($signed(px)), mx);
    check({tag, " py"}, int'($signed(py)), my);
    check({tag, " dir"}, int'(direction), md);
  endtask

  task automatic do_cmd(logic [3:0] k);
    model_cmd(k, cyc, 1'b1);
    pulse_key(k);
    wait_idle(100);
    check_pos("after cmd");
  endtask

  task automatic release_reset();
    mx = 1; my = 7; md = 0;
    expect_ev(EV_REF, cyc, 0);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    int ks [6];
    logic [3:0] k;
    for (int i = 0; i < 1024; i++) wall_map[i] = ($urandom_range(0, 4) == 0);
    mx = 1; my = 7; md = 0;

    tick(); tick();
    check_pos("reset");
    check("reset refresh", int'(refresh), 0);
    check("reset bump", int'(bump), 0);
    check("reset map_rd", int'(map_rd), 0);
    check("reset cmd_drop", int'(cmd_drop), 0);
    check("reset draw_err", int'(draw_err), 0);
    check("reset idle", int'(idle), 0);
    release_reset();
    wait_idle(100);
    check_pos("initial draw");

    wall_map[7*32+2] = 1'b0; do_cmd(4'b0010);
    wall_map[7*32+3] = 1'b1; do_cmd(4'b0010);
    wall_map[7*32+1] = 1'b0; do_cmd(4'b0001);
    do_cmd(4'b1000);
    do_cmd(4'b1000);
    wall_map[7*32+0] = 1'b0; do_cmd(4'b0010);
    do_cmd(4'b0010);
    do_cmd(4'b1010);
    do_cmd(4'b0111);

    repeat (60) begin
      k = 4'($urandom_range(1, 15));
      do_cmd(k);
    end

    // Reset while a draw is pending and two commands are queued.
    hold = 1'b1;
    n = cyc;
    model_cmd(4'b1000, n, 1'b1);
    pulse_key(4'b1000);
    pulse_key(4'b0100);
    pulse_key(4'b1000);
    tick();
    rstn = 1'b0;
    tick(); tick();
    exp_q.delete();
    mx = 1; my = 7; md = 0;
    check_pos("mid-op reset");
    release_reset();
    hold = 1'b0;
    wait_idle(100);
    check_pos("after mid-op reset");

    // Back-to-back keys while the draw is held: 4 queue, the 6th is dropped.
    ks = '{2, 2, 3, 3, 2, 2};
    hold = 1'b1;
    n = cyc;
    k = 4'b0001 << ks[0];
    model_cmd(k, n, 1'b1);
    expect_ev(EV_DROP, n + 5, 0);
    for (int i = 1; i < 5; i++) begin
      k = 4'b0001 << ks[i];
      model_cmd(k, 0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      k = 4'b0001 << ks[i];
      pulse_key(k);
    end
    hold = 1'b0;
    wait_idle(400);
    check_pos("after burst");

    // No done at all: draw gives up after TO cycles in S_DRAW.
    hold = 1'b1;
    n = cyc;
    model_cmd(4'b1000, n, 1'b1);
    pulse_key(4'b1000);
    while (cyc < n + 2 + TO) tick();
    check("draw_err before timeout", int'(draw_err), 0);
    check("idle before timeout", int'(idle), 0);
    tick();
    check("draw_err at timeout", int'(draw_err), 1);
    check("idle at timeout", int'(idle), 1);
    hold = 1'b0;
    repeat (20) tick();
    check("draw_err sticky", int'(draw_err), 1);
    check_pos("after timeout");

    check("leftover expected events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
